// File: rtl/avmm_burst_mover_if.sv
// avmm_burst_mover_if: Avalon-MM burst master/slave signal bundle
interface avmm_burst_mover_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32,
  parameter int BC_W = 4
);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [BC_W-1:0] burstcount;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  logic waitrequest;
  modport master(
    output address, read, write, writedata, byteenable, burstcount,
    input readdata, readdatavalid, waitrequest
  );
  modport slave(
    input address, read, write, writedata, byteenable, burstcount,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avmm_burst_mover.sv
// avmm_burst_mover: Avalon-MM burst copy/fill engine with boundary-safe splitting and graceful abort
module avmm_burst_mover #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 8,
  parameter int LEN_W = 16,
  parameter int BC_W = 4
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic cfg_mode,
  input  logic [DATA_W-1:0] cfg_fill,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic aborted,
  output logic [31:0] finish_count,
  avmm_burst_mover_if.master avm
);
  localparam int AW = $clog2(DATA_W / 8);
  localparam int IW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic [2:0] {IDLE, CHUNK, RD_CMD, RD_DATA, WR, FINISH} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0] rem;
  logic [BC_W-1:0] b, cnt, to_d, to_s, to_r, b_lim, b_n;
  logic mode, abort_l, go, ab, last, beat_rd, beat_wr;
  logic [DATA_W-1:0] fill;
  logic [DATA_W-1:0] fifo [2**IW];
  // a start coinciding with the done pulse is dropped
  assign go = start && !done && state == IDLE;
  assign ab = abort_l || (abort && busy);
  assign last = cnt == b - 1'b1;
  assign beat_rd = state == RD_DATA && avm.readdatavalid;
  assign beat_wr = state == WR && !avm.waitrequest;
  // burst size: never cross a MAX_BURST-word aligned boundary on either side
  always_comb begin
    to_d = BC_W'(MAX_BURST) - (BC_W'(dst >> AW) & BC_W'(MAX_BURST - 1));
    to_s = BC_W'(MAX_BURST) - (BC_W'(src >> AW) & BC_W'(MAX_BURST - 1));
    to_r = rem >= LEN_W'(MAX_BURST) ? BC_W'(MAX_BURST) : BC_W'(rem);
    b_lim = to_d < to_r ? to_d : to_r;
    b_n = !mode && to_s < b_lim ? to_s : b_lim;
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = !go ? IDLE : cfg_len == '0 ? FINISH : CHUNK;
      CHUNK:   nxt = ab ? FINISH : mode ? WR : RD_CMD;
      RD_CMD:  nxt = avm.waitrequest ? RD_CMD : RD_DATA;
      RD_DATA: nxt = beat_rd && last ? WR : RD_DATA;
      WR:      nxt = !(beat_wr && last) ? WR : (rem == LEN_W'(b) || ab) ? FINISH : CHUNK;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    avm.read = state == RD_CMD;
    avm.write = state == WR;
    avm.address = state == RD_CMD ? src : state == WR ? dst : '0;
    avm.burstcount = (state == RD_CMD || state == WR) ? b : '0;
    avm.writedata = state != WR ? '0 : mode ? fill : fifo[IW'(cnt)];
    avm.byteenable = '1;
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      src <= '0;
      dst <= '0;
      rem <= '0;
      b <= '0;
      cnt <= '0;
      mode <= 1'b0;
      fill <= '0;
      abort_l <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      finish_count <= '0;
    end else begin
      done <= state == FINISH;
      if (go) begin
        src <= cfg_src & ~ADDR_W'(2**AW - 1);
        dst <= cfg_dst & ~ADDR_W'(2**AW - 1);
        rem <= cfg_len;
        mode <= cfg_mode;
        fill <= cfg_fill;
        busy <= cfg_len != '0;
        abort_l <= 1'b0;
        aborted <= 1'b0;
      end else if (busy && abort) abort_l <= 1'b1;
      if (state == CHUNK) b <= b_n;
      if (state == CHUNK) cnt <= '0;
      else if (beat_rd || beat_wr) cnt <= last ? '0 : cnt + 1'b1;
      if (beat_wr && last) begin
        src <= src + (ADDR_W'(b) << AW);
        dst <= dst + (ADDR_W'(b) << AW);
        rem <= rem - LEN_W'(b);
      end
      if (state == FINISH) begin
        busy <= 1'b0;
        aborted <= abort_l;
        finish_count <= finish_count + 1'b1;
      end
    end
  always_ff @(posedge clk_clk)
    if (beat_rd) fifo[IW'(cnt)] <= avm.readdata;
endmodule

// File: tb/tb_avmm_burst_mover.sv
// tb_avmm_burst_mover: scoreboard bench with an Avalon burst slave model
module tb_avmm_burst_mover;
  logic clk_clk = 0, reset_reset = 0;
  logic [26:0] cfg_src = 0, cfg_dst = 0;
  logic [15:0] cfg_len = 0;
  logic cfg_mode = 0, start = 0, abort = 0;
  logic [31:0] cfg_fill = 0;
  logic busy, done, aborted;
  logic [31:0] finish_count;
  avmm_burst_mover_if #(.ADDR_W(27), .DATA_W(32), .BC_W(4)) avm();
  avmm_burst_mover #(.ADDR_W(27), .DATA_W(32), .MAX_BURST(8), .LEN_W(16), .BC_W(4)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len), .cfg_mode(cfg_mode), .cfg_fill(cfg_fill), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .finish_count(finish_count), .avm(avm));
  always #5 clk_clk = ~clk_clk;

  typedef struct {logic [26:0] a; logic [31:0] d; int bc;} wexp_t;
  typedef struct {logic [26:0] a; int bc;} rexp_t;
  typedef struct {logic ab; int cnt;} dexp_t;
  wexp_t wq[$];
  rexp_t rq[$];
  dexp_t dq[$];
  logic [26:0] pend[$];
  logic [31:0] mem [4096];
  int n_chk = 0, n_fail = 0, cyc = 0, n_rd = 0, n_wb = 0, n_done = 0;
  int start_cyc = 0, first_cyc = -1, done_cyc = 0;
  bit rand_wait = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_rd(input logic [26:0] a, input int bc);
    rq.push_back('{a, bc});
  endtask

  task automatic exp_wr(input logic [26:0] d, input logic [26:0] s, input int bc, input bit fm, input logic [31:0] f);
    for (int i = 0; i < bc; i++)
      wq.push_back('{d + 27'(4 * i), fm ? f : (32'h5A00_0000 | 32'(s + 27'(4 * i))), i == 0 ? bc : 0});
  endtask

  task automatic exp_done(input logic ab, input int c);
    dq.push_back('{ab, c});
  endtask

  task automatic run(input logic [26:0] s, input logic [26:0] d, input int len, input logic m, input logic [31:0] f);
    @(posedge clk_clk); #1;
    cfg_src = s; cfg_dst = d; cfg_len = 16'(len); cfg_mode = m; cfg_fill = f;
    start = 1; start_cyc = cyc; first_cyc = -1;
    @(posedge clk_clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int n0);
    for (int i = 0; i < 2000 && n_done == n0; i++) @(negedge clk_clk);
    chk(name, n_done > n0, 1);
  endtask

  initial forever @(posedge clk_clk) cyc++;

  // slave model and monitor: drives waitrequest/readdata, checks every handshake against the queues
  initial begin
    wexp_t w;
    rexp_t r;
    dexp_t d;
    logic [26:0] t, wbase, wa, pa;
    logic [3:0] pbc;
    logic [31:0] pd;
    int wleft, widx;
    bit pst;
    wleft = 0; widx = 0; pst = 0; wbase = 0; pa = 0; pbc = 0; pd = 0;
    avm.waitrequest = 0; avm.readdatavalid = 0; avm.readdata = 0;
    forever begin
      @(negedge clk_clk);
      if (reset_reset) begin
        pend.delete();
        avm.readdatavalid = 0;
        avm.waitrequest = 0;
        wleft = 0;
        pst = 0;
      end else begin
        avm.readdatavalid = pend.size() > 0;
        if (pend.size() > 0) begin
          t = pend.pop_front();
          avm.readdata = mem[t[13:2]];
        end
        if (pst) begin
          chk("stall_write", avm.write, 1);
          chk("stall_addr", avm.address, pa);
          chk("stall_bc", avm.burstcount, pbc);
          chk("stall_wdata", avm.writedata, pd);
        end
        avm.waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        if ((avm.read || avm.write) && first_cyc < 0) first_cyc = cyc;
        if (avm.read && !avm.waitrequest) begin
          n_rd++;
          chk("rd_expected", rq.size() > 0, 1);
          if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("rd_addr", avm.address, r.a);
            chk("rd_bc", avm.burstcount, r.bc);
          end
          for (int i = 0; i < int'(avm.burstcount); i++) pend.push_back(avm.address + 27'(4 * i));
        end
        if (avm.write && !avm.waitrequest) begin
          if (wleft == 0) begin
            wbase = avm.address;
            wleft = int'(avm.burstcount);
            widx = 0;
          end
          wa = wbase + 27'(4 * widx);
          chk("wr_expected", wq.size() > 0, 1);
          if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("wr_addr", wa, w.a);
            chk("wr_data", avm.writedata, w.d);
            if (widx == 0) begin
              chk("wr_bc", avm.burstcount, w.bc);
              chk("wr_be", avm.byteenable, 4'hF);
            end
          end
          mem[wa[13:2]] = avm.writedata;
          widx++;
          wleft--;
          n_wb++;
        end
        pst = avm.write && avm.waitrequest;
        pa = avm.address;
        pbc = avm.burstcount;
        pd = avm.writedata;
        if (done) begin
          n_done++;
          done_cyc = cyc;
          chk("done_expected", dq.size() > 0, 1);
          if (dq.size() > 0) begin
            d = dq.pop_front();
            chk("done_aborted", aborted, d.ab);
            chk("done_finish_count", finish_count, d.cnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, wb0, rd0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | 32'(i << 2);
    #1 reset_reset = 1;
    repeat (3) @(posedge clk_clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_finish_count", finish_count, 0);
    chk("rst_read", avm.read, 0);
    chk("rst_write", avm.write, 0);
    reset_reset = 0;

    // copy 20 words: 8 + 8 + 4
    exp_rd(27'h1000, 8); exp_wr(27'h2000, 27'h1000, 8, 0, 0);
    exp_rd(27'h1020, 8); exp_wr(27'h2020, 27'h1020, 8, 0, 0);
    exp_rd(27'h1040, 4); exp_wr(27'h2040, 27'h1040, 4, 0, 0);
    exp_done(0, 1);
    n0 = n_done;
    run(27'h1000, 27'h2000, 20, 0, 0);
    wait_done("copy_done_timeout", n0);
    chk("copy_rd_latency", first_cyc - start_cyc, 2);
    for (int i = 0; i < 20; i++) chk("copy_mem", mem[12'('h800 + i)], 32'h5A00_1000 + 32'(4 * i));

    // destination two words short of a 32-byte boundary: 2 then 6
    exp_rd(27'h1000, 2); exp_wr(27'h2018, 27'h1000, 2, 0, 0);
    exp_rd(27'h1008, 6); exp_wr(27'h2020, 27'h1008, 6, 0, 0);
    exp_done(0, 2);
    n0 = n_done;
    run(27'h1000, 27'h2018, 8, 0, 0);
    wait_done("split_done_timeout", n0);

    // fill under random backpressure
    rand_wait = 1;
    exp_wr(27'h3000, 0, 5, 1, 32'hDEADBEEF);
    exp_done(0, 3);
    n0 = n_done;
    run(27'h0, 27'h3000, 5, 1, 32'hDEADBEEF);
    wait_done("fill_done_timeout", n0);
    rand_wait = 0;
    chk("fill_wr_latency", first_cyc - start_cyc, 2);
    for (int i = 0; i < 5; i++) chk("fill_mem", mem[12'('hC00 + i)], 32'hDEADBEEF);

    // abort on third write beat of the first burst
    exp_rd(27'h1000, 8); exp_wr(27'h2400, 27'h1000, 8, 0, 0);
    exp_done(1, 4);
    n0 = n_done;
    wb0 = n_wb;
    run(27'h1000, 27'h2400, 32, 0, 0);
    for (int i = 0; i < 200 && n_wb < wb0 + 2; i++) begin @(posedge clk_clk); #1; end
    abort = 1;
    @(posedge clk_clk); #1;
    abort = 0;
    wait_done("abort_done_timeout", n0);
    repeat (20) @(posedge clk_clk);
    #1;
    chk("abort_aborted", aborted, 1);
    chk("abort_beats", n_wb - wb0, 8);

    // zero length, then a start coinciding with done
    exp_done(0, 5);
    n0 = n_done;
    run(27'h0, 27'h3800, 0, 1, 32'h11111111);
    @(posedge clk_clk); #1;
    cfg_len = 4;
    start = 1;
    @(posedge clk_clk); #1;
    start = 0;
    wait_done("zero_done_timeout", n0);
    chk("zero_done_latency", done_cyc - start_cyc, 2);
    repeat (10) @(posedge clk_clk);
    #1;
    chk("zero_no_bus", first_cyc, -1);
    chk("zero_single_done", n_done, n0 + 1);

    // start while busy is ignored
    exp_rd(27'h1000, 8); exp_wr(27'h2800, 27'h1000, 8, 0, 0);
    exp_rd(27'h1020, 8); exp_wr(27'h2820, 27'h1020, 8, 0, 0);
    exp_done(0, 6);
    n0 = n_done;
    run(27'h1000, 27'h2800, 16, 0, 0);
    repeat (4) @(posedge clk_clk);
    #1;
    cfg_src = 27'h1100; cfg_dst = 27'h3C00; cfg_len = 4; cfg_mode = 1;
    start = 1;
    @(posedge clk_clk); #1;
    start = 0;
    wait_done("busy_done_timeout", n0);
    repeat (10) @(posedge clk_clk);
    #1;
    chk("busy_single_done", n_done, n0 + 1);
    chk("busy_finish_count", finish_count, 6);
    chk("busy_idle", busy, 0);

    // reset during RD_DATA, then a clean transfer
    exp_rd(27'h1000, 8);
    rd0 = n_rd;
    run(27'h1000, 27'h2C00, 16, 0, 0);
    for (int i = 0; i < 100 && n_rd == rd0; i++) begin @(posedge clk_clk); #1; end
    chk("rst_mid_rd_seen", n_rd > rd0, 1);
    reset_reset = 1;
    #1;
    chk("rst_mid_read", avm.read, 0);
    chk("rst_mid_write", avm.write, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_finish_count", finish_count, 0);
    wq.delete(); rq.delete(); dq.delete();
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset = 0;
    exp_rd(27'h1000, 8); exp_wr(27'h3400, 27'h1000, 8, 0, 0);
    exp_done(0, 1);
    n0 = n_done;
    run(27'h1000, 27'h3400, 8, 0, 0);
    wait_done("post_rst_done_timeout", n0);
    for (int i = 0; i < 8; i++) chk("post_rst_mem", mem[12'('hD00 + i)], 32'h5A00_1000 + 32'(4 * i));

    repeat (5) @(posedge clk_clk);
    chk("left_writes", wq.size(), 0);
    chk("left_reads", rq.size(), 0);
    chk("left_dones", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
